// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU run controller: sequencer states,
// the halt opcode, default widths and the program base-address lookup.
package cpu_pkg;

    localparam int unsigned DEF_PC_W    = 10;
    localparam int unsigned DEF_INSTR_W = 9;
    localparam int unsigned DEF_CNT_W   = 16;

    localparam logic [8:0] HALT_INSTR = 9'b010000000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        DONE     = 3'd3,
        FINISHED = 3'd4
    } seq_state_t;

    function automatic int unsigned prog_base(
        input logic [1:0]  idx,
        input int unsigned base0,
        input int unsigned base1,
        input int unsigned base2
    );
        case (idx)
            2'd0:    return base0;
            2'd1:    return base1;
            default: return base2;
        endcase
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating count of RUN cycles with a watchdog terminal flag that is raised
// one cycle before the limit is reached.
module run_cycle_counter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/program_sequencer.sv
// Run controller for the single-cycle CPU: start/done handshake, PC base load,
// execution enable, halt detection and run-cycle watchdog for three programs.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W       = DEF_PC_W,
    parameter int unsigned INSTR_W    = DEF_INSTR_W,
    parameter int unsigned NUM_PROGS  = 3,
    parameter int unsigned PROG0_BASE = 0,
    parameter int unsigned PROG1_BASE = 256,
    parameter int unsigned PROG2_BASE = 512,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic               cpu_en,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_load_value,
    output logic [1:0]         prog_idx,
    output logic               done,
    output logic               all_done,
    output logic               timeout,
    output logic [CNT_W-1:0]   run_cycles
);

    seq_state_t      state_q, state_d;
    logic            start_q;
    logic            pc_load_q, pc_load_d;
    logic [PC_W-1:0] pc_load_value_q, pc_load_value_d;
    logic [1:0]      prog_idx_q, prog_idx_d;
    logic            done_q, done_d;
    logic            all_done_q, all_done_d;
    logic            timeout_q, timeout_d;

    logic fall;
    logic halt_cond;
    logic run_terminal;
    logic cnt_clear;
    logic cnt_enable;

    assign fall      = start_q & ~start;
    assign halt_cond = (instruction == INSTR_W'(HALT_INSTR));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d         = state_q;
        pc_load_d       = 1'b0;
        pc_load_value_d = pc_load_value_q;
        prog_idx_d      = prog_idx_q;
        done_d          = done_q;
        all_done_d      = all_done_q;
        timeout_d       = timeout_q;
        cnt_clear       = 1'b0;
        cnt_enable      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d         = LOAD;
                    pc_load_d       = 1'b1;
                    pc_load_value_d = PC_W'(prog_base(prog_idx_q, PROG0_BASE, PROG1_BASE, PROG2_BASE));
                end
            end
            LOAD: begin
                state_d   = RUN;
                cnt_clear = 1'b1;
                timeout_d = 1'b0;
            end
            RUN: begin
                cnt_enable = 1'b1;
                // Halt wins over the watchdog, so a halt on the last allowed cycle is not a timeout.
                if (halt_cond) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (run_terminal) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    done_d = 1'b0;
                    if (prog_idx_q == 2'(NUM_PROGS - 1)) begin
                        all_done_d = 1'b1;
                        state_d    = FINISHED;
                    end else begin
                        prog_idx_d = prog_idx_q + 2'd1;
                        state_d    = IDLE;
                    end
                end
            end
            FINISHED: begin
                state_d = FINISHED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            state_q         <= IDLE;
            start_q         <= 1'b0;
            pc_load_q       <= 1'b0;
            pc_load_value_q <= '0;
            prog_idx_q      <= 2'd0;
            done_q          <= 1'b0;
            all_done_q      <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_q         <= start;
            pc_load_q       <= pc_load_d;
            pc_load_value_q <= pc_load_value_d;
            prog_idx_q      <= prog_idx_d;
            done_q          <= done_d;
            all_done_q      <= all_done_d;
            timeout_q       <= timeout_d;
        end
    end

    run_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (run_cycles),
        .terminal (run_terminal)
    );

    assign cpu_en        = (state_q == RUN) && !halt_cond;
    assign pc_load       = pc_load_q;
    assign pc_load_value = pc_load_value_q;
    assign prog_idx      = prog_idx_q;
    assign done          = done_q;
    assign all_done      = all_done_q;
    assign timeout       = timeout_q;

endmodule
